load_prog_engine: RTL
=====================

# load_prog_engine

Load-program sequencer and memory-bus master that sits directly upstream of `mem_sys`. It owns the `mem_in_bus_t` port into `mem_sys` and implements the UM "load program" operation as a hardware copy: allocate a new array, copy the source array word by word, then make the new array the zero array. While idle it passes the CPU's memory requests through unchanged. While busy it drives the bus itself and blocks the CPU.

## Interface
- No parameters; all datapaths are 32 bits, fixed by `mem_in_bus_t`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_bus`  in  `mem_in_bus_t`  CPU request; forwarded to `mem_bus` only in IDLE.
- `start`  in  1  begin a load-program; sampled only in IDLE.
- `src_addr`  in  32  base address of the source array; latched on accepted `start`.
- `word_count`  in  32  source array length in words; latched on accepted `start`.
- `mem_data`  in  32  `mem_sys` `data_out`, registered, valid the cycle after the request.
- `mem_bus`  out  `mem_in_bus_t`  request to `mem_sys`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse when the operation completes.
- `new_base`  out  32  base address of the new zero array; held until the next completed copy.

## Operation
- Bus modes: 00 read, 01 write, 10 alloc (`offset` = size, returns base), 11 set zero array (`data` = base).
- `mem_sys` executes a request every cycle, so the idle pattern is a read: mode 00, address 0, offset 0, data 0.
- States:
  - IDLE: `mem_bus` = `cpu_bus`, passed through combinationally.
    - On `start`=1 with `src_addr`≠0: latch `src_addr` and `word_count`, clear index `i`, go to ALLOC.
    - On `start`=1 with `src_addr`=0: go to DONE with no bus traffic and `new_base` unchanged (UM jump-only case).
  - ALLOC: drive mode 10, offset = count; go to AWAIT.
  - AWAIT: drive the idle pattern; capture `dst` = `mem_data` at the edge.
    - count=0: go to SETZERO.
    - Otherwise: go to READ.
  - READ: drive mode 00, address = src, offset = i; go to WRITE.
  - WRITE: drive mode 01, address = dst, offset = i, data = `mem_data`.
    - If i = count−1: go to SETZERO.
    - Otherwise: i <= i+1, go to READ.
  - SETZERO: drive mode 11, data = dst; load `new_base` <= dst; go to DONE.
  - DONE: `done`=1, drive the idle pattern; go to IDLE.
- In every non-IDLE state, `cpu_bus` is ignored entirely. The CPU must hold off requests while `busy`=1.
- `start` while busy is ignored and not queued. Input changes while busy are also ignored.
- Index rule: `i` is 32 bits and is compared by equality with count−1, so it never wraps. count−1 is evaluated only when count≠0.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, i=0, dst=0, `new_base`=0, `done`=0, `busy`=0.
- While `reset`=0, `mem_bus` = the idle pattern regardless of `cpu_bus`.
- An aborted copy is abandoned with no cleanup. The partially allocated array is leaked, and the zero array is not changed.
- Count cycles from the edge E0 that samples `start`:
  - ALLOC occupies cycle 1.
  - AWAIT occupies cycle 2.
  - Word k is read in cycle 3+2k and written in cycle 4+2k.
  - SETZERO occupies cycle 2N+3; `done` is high in cycle 2N+4.
  - `busy` is high for cycles 1 through 2N+4.
- count=0: SETZERO in cycle 3, `done` in cycle 4.
- src=0: `done` in cycle 1; `busy` is high in cycle 1 only.
- Write data in WRITE is the `mem_data` produced by the READ in the immediately preceding cycle. No extra buffering is needed.
- `new_base` updates at the end of SETZERO, so it is valid when `done` is high.
- A `start` arriving in the same cycle as DONE is ignored. A new `start` is accepted from the following IDLE cycle.

## Test plan
- src=0x100, count=3, source contents {0xA, 0xB, 0xC}, alloc returns 0x400:
  - Writes (0x400,0)=0xA, (0x400,1)=0xB, (0x400,2)=0xC.
  - Mode 11 with data 0x400 appears in cycle 9.
  - `done` in cycle 10; `new_base`=0x400.
- count=0, src=0x100: alloc offset 0, then SETZERO with the returned base in cycle 3, then `done` in cycle 4. No read or write issued.
- src=0: `done` in cycle 1; `mem_bus` never leaves pass-through/idle; `new_base` keeps its prior value.
- IDLE pass-through: `cpu_bus` = {addr 5, offset 2, data 7, mode 01} appears on `mem_bus` in the same cycle.
  - A `start` in that same cycle passes the CPU write, then ALLOC in the next cycle.
- Second `start` pulsed mid-copy with different `src_addr`: ignored; copy completes with the original source.
- `reset` driven low during WRITE of word 1 of a 4-word copy:
  - Immediately `busy`=0 and `mem_bus` idle; `new_base`=0.
  - No mode 11 is ever issued.
  - After release, the engine accepts a new `start`.

Source files
------------

// File: rtl/load_prog_engine_if.sv
//------------------------------------------------------------------------------
// load_prog_engine_if
// Memory request bus into mem_sys: mode, address, offset, data.
// Modes: 00 read, 01 write, 10 alloc (offset = size), 11 set zero array.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface load_prog_engine_if;
  logic [1:0]  mode;
  logic [31:0] addr;
  logic [31:0] offset;
  logic [31:0] data;

  modport master (output mode, addr, offset, data);
  modport slave  (input  mode, addr, offset, data);
endinterface

`default_nettype wire

// File: rtl/load_prog_engine.sv
//------------------------------------------------------------------------------
// load_prog_engine
// Hardware "load program" sequencer: allocate a new array, copy the source
// array word by word, then make the copy the zero array. While idle the CPU
// request is passed straight through to mem_sys.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_prog_engine (
  input  logic                      clk,
  input  logic                      reset,      // asynchronous, active low
  load_prog_engine_if.slave         cpu_bus,
  input  logic                      start,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               word_count,
  input  logic [31:0]               mem_data,
  load_prog_engine_if.master        mem_bus,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               new_base
);

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_ALLOC = 2'b10;
  localparam logic [1:0] MODE_SETZ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALLOC   = 3'd1,
    S_AWAIT   = 3'd2,
    S_READ    = 3'd3,
    S_WRITE   = 3'd4,
    S_SETZERO = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] nb_q,  nb_d;

  logic [1:0]  bus_mode;
  logic [31:0] bus_addr;
  logic [31:0] bus_off;
  logic [31:0] bus_data;

  // Only consulted in WRITE, where the count is known to be non-zero.
  logic [31:0] cnt_m1;
  assign cnt_m1 = cnt_q - 32'd1;

  // State and datapath registers; async reset abandons any copy in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dst_q   <= '0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dst_q   <= dst_d;
      nb_q    <= nb_d;
    end
  end

  // Next-state logic and bus drive; the idle pattern is a read of address 0.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dst_d    = dst_q;
    nb_d     = nb_q;
    bus_mode = MODE_READ;
    bus_addr = '0;
    bus_off  = '0;
    bus_data = '0;

    unique case (state_q)
      S_IDLE: begin
        // Pass-through is suppressed while reset is held.
        if (reset) begin
          bus_mode = cpu_bus.mode;
          bus_addr = cpu_bus.addr;
          bus_off  = cpu_bus.offset;
          bus_data = cpu_bus.data;
        end
        if (start) begin
          if (src_addr != 32'd0) begin
            src_d   = src_addr;
            cnt_d   = word_count;
            idx_d   = '0;
            state_d = S_ALLOC;
          end else begin
            // Jump-only load: nothing to copy, zero array untouched.
            state_d = S_DONE;
          end
        end
      end
      S_ALLOC: begin
        bus_mode = MODE_ALLOC;
        bus_off  = cnt_q;
        state_d  = S_AWAIT;
      end
      S_AWAIT: begin
        // Allocated base arrives on mem_data this cycle.
        dst_d   = mem_data;
        state_d = (cnt_q == 32'd0) ? S_SETZERO : S_READ;
      end
      S_READ: begin
        bus_mode = MODE_READ;
        bus_addr = src_q;
        bus_off  = idx_q;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        // mem_data holds the word fetched by the preceding READ.
        bus_mode = MODE_WRITE;
        bus_addr = dst_q;
        bus_off  = idx_q;
        bus_data = mem_data;
        if (idx_q == cnt_m1) begin
          state_d = S_SETZERO;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = S_READ;
        end
      end
      S_SETZERO: begin
        bus_mode = MODE_SETZ;
        bus_data = dst_q;
        nb_d     = dst_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_bus.mode   = bus_mode;
  assign mem_bus.addr   = bus_addr;
  assign mem_bus.offset = bus_off;
  assign mem_bus.data   = bus_data;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign new_base = nb_q;

endmodule

`default_nettype wire
